// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared RV32I load/store funct3 codes and responder FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // RV32I load/store width codes (stores use only B/H/W)
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True when funct3 is not a legal code for the given direction
  function automatic logic f3_illegal(input logic i_write, input logic [2:0] i_f3);
    if (i_write) begin
      return (i_f3 > F3_W);
    end
    return (i_f3 == 3'd3) || (i_f3 == 3'd6) || (i_f3 == 3'd7);
  endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Brief    : Combinational byte-lane logic: store byte enables and data
//            shifting, load lane select and extension, misalignment and
//            illegal-funct3 detection.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import riscv_pkg::*;
(
  input  logic        i_write,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata_sh,
  output logic [31:0] o_rdata_ext,
  output logic        o_err
);

  logic [4:0]  w_shamt;
  logic [31:0] w_rword_sh;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_misalign;

  assign w_shamt    = {i_addr_lo, 3'b000};
  assign w_rword_sh = i_rword >> w_shamt;
  assign o_wdata_sh = i_wdata << w_shamt;

  assign w_is_half  = (i_funct3 == F3_H) || (i_funct3 == F3_HU);
  assign w_is_word  = (i_funct3 == F3_W);
  assign w_misalign = (w_is_half && i_addr_lo[0]) || (w_is_word && (i_addr_lo != 2'b00));
  assign o_err      = w_misalign || f3_illegal(i_write, i_funct3);

  // Byte enables: one lane for bytes, a lane pair for halfwords, all for words
  always_comb begin
    o_be = 4'b0000;
    case (i_funct3)
      F3_B:    o_be = 4'b0001 << i_addr_lo;
      F3_H:    o_be = 4'b0011 << i_addr_lo;
      F3_W:    o_be = 4'b1111;
      default: o_be = 4'b0000;
    endcase
  end

  // Load result: pick the addressed lane(s) then sign- or zero-extend
  always_comb begin
    o_rdata_ext = 32'd0;
    case (i_funct3)
      F3_B:    o_rdata_ext = {{24{w_rword_sh[7]}}, w_rword_sh[7:0]};
      F3_BU:   o_rdata_ext = {24'd0, w_rword_sh[7:0]};
      F3_H:    o_rdata_ext = {{16{w_rword_sh[15]}}, w_rword_sh[15:0]};
      F3_HU:   o_rdata_ext = {16'd0, w_rword_sh[15:0]};
      F3_W:    o_rdata_ext = i_rword;
      default: o_rdata_ext = 32'd0;
    endcase
  end

endmodule : dmem_lane_align
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Data-memory responder for the RV32 LSU port. One outstanding
//            request, programmable wait states, byte/half/word access with
//            RV32I extension and error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_error
);

  localparam int         c_AW        = $clog2(DEPTH);
  localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_error;
  logic [31:0] r_mem [DEPTH];

  // With zero wait states RESP is entered on the accept edge itself, before
  // the latch holds anything, so the live request is evaluated in IDLE.
  logic        w_in_idle;
  logic        w_cur_write;
  logic [2:0]  w_cur_funct3;
  logic [31:0] w_cur_addr;
  logic [31:0] w_cur_wdata;
  logic [c_AW-1:0] w_idx;
  logic        w_range_err;
  logic        w_lane_err;
  logic        w_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_sh;
  logic [31:0] w_rdata_ext;
  logic [31:0] w_rsp_rdata;
  logic        w_enter_resp;
  logic        w_mem_we;

  assign w_in_idle    = (r_state == ST_IDLE);
  assign w_cur_write  = w_in_idle ? i_req_write  : r_write;
  assign w_cur_funct3 = w_in_idle ? i_req_funct3 : r_funct3;
  assign w_cur_addr   = w_in_idle ? i_req_addr   : r_addr;
  assign w_cur_wdata  = w_in_idle ? i_req_wdata  : r_wdata;

  assign w_idx       = w_cur_addr[c_AW+1:2];
  assign w_range_err = (w_cur_addr >> (c_AW + 2)) != 32'd0;
  assign w_err       = w_range_err || w_lane_err;
  assign w_rsp_rdata = (w_err || w_cur_write) ? 32'd0 : w_rdata_ext;

  assign w_enter_resp = (w_in_idle && i_req_valid && (WAIT_CYCLES == 0)) ||
                        ((r_state == ST_WAIT) && (r_cnt == 4'd0));
  assign w_mem_we     = i_rst_n && w_enter_resp && w_cur_write && !w_err;

  dmem_lane_align u_lane (
    .i_write     (w_cur_write),
    .i_funct3    (w_cur_funct3),
    .i_addr_lo   (w_cur_addr[1:0]),
    .i_wdata     (w_cur_wdata),
    .i_rword     (r_mem[w_idx]),
    .o_be        (w_be),
    .o_wdata_sh  (w_wdata_sh),
    .o_rdata_ext (w_rdata_ext),
    .o_err       (w_lane_err)
  );

  // RAM: byte-lane write on the RESP-entry edge; contents survive reset
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
        end
      end
    end
  end

  // Request FSM with wait counter, request latch and registered response
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_write     <= i_req_write;
            r_funct3    <= i_req_funct3;
            r_addr      <= i_req_addr;
            r_wdata     <= i_req_wdata;
            r_req_ready <= 1'b0;
            r_cnt       <= c_WAIT_LOAD;
            if (WAIT_CYCLES > 0) begin
              r_state <= ST_WAIT;
            end else begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rsp_rdata;
              r_rsp_error <= w_err;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_error <= w_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_error <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_error = r_rsp_error;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed, table-driven bench for dmem_responder (WAIT_CYCLES=2
//            main instance, WAIT_CYCLES=0 / DEPTH=16 secondary instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid0 = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_ready = 1'b0;

  logic        req_ready, rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic        req_ready0, rsp_valid0, rsp_error0;
  logic [31:0] rsp_rdata0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_write(req_write), .i_req_funct3(req_funct3), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_error(rsp_error)
  );

  dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid0), .o_req_ready(req_ready0),
    .i_req_write(req_write), .i_req_funct3(req_funct3), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_rsp_valid(rsp_valid0), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata0), .o_rsp_error(rsp_error0)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    else n_pass++;
  endtask

  // One full transaction on the main instance; inputs are scrambled right
  // after the accept edge so only the accept-edge sample can matter.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    int g;
    @(negedge clk);
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata; er = rsp_error;
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  vec_t vecs[20];

  initial begin
    logic [31:0] rd, held;
    logic        er;
    int          lat, bad, g;

    vecs[0]  = '{1'b1, F3_W,  32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, F3_W,  32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, F3_W,  32'h0,    32'h80817F01, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, F3_B,  32'h3,    32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, F3_BU, 32'h3,    32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, F3_H,  32'h2,    32'h0,        32'hFFFF8081, 1'b0};
    vecs[6]  = '{1'b0, F3_HU, 32'h0,    32'h0,        32'h00007F01, 1'b0};
    vecs[7]  = '{1'b0, F3_B,  32'h0,    32'h0,        32'h00000001, 1'b0};
    vecs[8]  = '{1'b1, F3_W,  32'h4,    32'h11223344, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, F3_B,  32'h5,    32'hFFFFFFAA, 32'h0,        1'b0};
    vecs[10] = '{1'b0, F3_W,  32'h4,    32'h0,        32'h1122AA44, 1'b0};
    vecs[11] = '{1'b0, F3_W,  32'h6,    32'h0,        32'h0,        1'b1};
    vecs[12] = '{1'b1, F3_H,  32'h3,    32'h0000BEEF, 32'h0,        1'b1};
    vecs[13] = '{1'b1, 3'd3,  32'h0,    32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[14] = '{1'b0, F3_W,  32'h0,    32'h0,        32'h80817F01, 1'b0};
    vecs[15] = '{1'b0, F3_W,  32'h1000, 32'h0,        32'h0,        1'b1};
    vecs[16] = '{1'b0, 3'd3,  32'h0,    32'h0,        32'h0,        1'b1};
    vecs[17] = '{1'b1, F3_H,  32'h6,    32'h12345566, 32'h0,        1'b0};
    vecs[18] = '{1'b0, F3_W,  32'h4,    32'h0,        32'h5566AA44, 1'b0};
    vecs[19] = '{1'b1, F3_W,  32'h20,   32'h12345678, 32'h0,        1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Table of directed transactions
    for (int i = 0; i < 20; i++) begin
      do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_error", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
    end

    // Reset mid-WAIT abandons an accepted store to 0x20
    @(negedge clk);
    req_write = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midwait_accepted", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("midrst_rsp_error", 32'(rsp_error), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    do_req(1'b0, F3_W, 32'h20, 32'h0, rd, er, lat);
    chk("midrst_lw20", rd, 32'h12345678);

    // Stall: rsp_ready low 10 cycles with a second request waiting
    @(negedge clk);
    req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h0;
    g = 0;
    while (!rsp_valid && g < 50) begin @(posedge clk); #1; g++; end
    held = rsp_rdata;
    chk("stall_first_rdata", held, 32'hDEADBEEF);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_rdata !== held || req_ready !== 1'b0) bad++;
    end
    chk("stall_stable", 32'(bad), 32'd0);
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    chk("stall_ready_after", 32'(req_ready), 32'd1);
    chk("stall_valid_after", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("stall_second_accept", 32'(req_ready), 32'd0);
    g = 0;
    while (!rsp_valid && g < 50) begin @(posedge clk); #1; g++; end
    chk("stall_second_rdata", rsp_rdata, 32'h80817F01);
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;

    // Zero wait states: response in the cycle after accept
    @(negedge clk);
    req_write = 1'b1; req_funct3 = F3_W; req_addr = 32'h8; req_wdata = 32'h000055AA; req_valid0 = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    chk("w0_sw_valid", 32'(rsp_valid0), 32'd1);
    chk("w0_sw_ready", 32'(req_ready0), 32'd0);
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    @(negedge clk);
    req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h8; req_valid0 = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    chk("w0_lw_valid", 32'(rsp_valid0), 32'd1);
    chk("w0_lw_rdata", rsp_rdata0, 32'h000055AA);
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    @(negedge clk);
    req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h40; req_valid0 = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    chk("w0_range_error", 32'(rsp_error0), 32'd1);
    chk("w0_range_rdata", rsp_rdata0, 32'd0);
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_dmem_responder
`default_nettype wire
